// File: rtl/lsu.sv
// Load/store unit: turns one execute-stage memory access into a single
// request/acknowledge bus transfer and returns the aligned, extended load result.

package lsu_pkg;
  localparam logic [2:0] MEM_B   = 3'b000;
  localparam logic [2:0] MEM_H   = 3'b001;
  localparam logic [2:0] MEM_W   = 3'b010;
  localparam logic [2:0] MEM_BU  = 3'b100;
  localparam logic [2:0] MEM_HU  = 3'b101;
  localparam logic [2:0] NOT_MEM = 3'b111;
endpackage

module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_we,
  input  logic [2:0]  in_sel,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  function automatic logic is_mem(input logic [2:0] sel);
    return (sel == MEM_B) || (sel == MEM_BU) || (sel == MEM_H) ||
           (sel == MEM_HU) || (sel == MEM_W);
  endfunction

  function automatic logic misaligned(input logic [2:0] sel, input logic [1:0] off);
    logic r;
    case (sel)
      MEM_H, MEM_HU: r = off[0];
      MEM_W:         r = (off != 2'b00);
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] sel, input logic [1:0] off);
    logic [3:0] r;
    case (sel)
      MEM_B, MEM_BU: r = 4'b0001 << off;
      MEM_H, MEM_HU: r = 4'b0011 << {off[1], 1'b0};
      default:       r = 4'b1111;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [2:0] sel, input logic [31:0] wd);
    logic [31:0] r;
    case (sel)
      MEM_B, MEM_BU: r = {4{wd[7:0]}};
      MEM_H, MEM_HU: r = {2{wd[15:0]}};
      default:       r = wd;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] sel, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (sel)
      MEM_B:   r = {{24{b[7]}}, b};
      MEM_BU:  r = {24'h0, b};
      MEM_H:   r = {{16{h[15]}}, h};
      MEM_HU:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_rdata_q, out_rdata_d;
  logic        out_err_q, out_err_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    out_valid_d = 1'b0;
    out_rdata_d = out_rdata_q;
    out_err_d   = out_err_q;

    case (state_q)
      IDLE: begin
        if (in_valid && is_mem(in_sel)) begin
          if (misaligned(in_sel, in_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            we_d    = in_we;
            sel_d   = in_sel;
            addr_d  = in_addr;
            be_d    = lane_be(in_sel, in_addr[1:0]);
            wdata_d = lane_wdata(in_sel, in_wdata);
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (bus_ack) begin
          rdata_d = bus_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        // The result is formatted here and registered, so it appears one cycle after RESP.
        state_d     = IDLE;
        out_valid_d = 1'b1;
        out_err_d   = err_q;
        out_rdata_d = (err_q || we_q) ? 32'h0 : extend_load(sel_q, addr_q[1:0], rdata_q);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      sel_q       <= MEM_W;
      addr_q      <= 32'h0;
      be_q        <= 4'h0;
      wdata_q     <= 32'h0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0;
      out_valid_q <= 1'b0;
      out_rdata_q <= 32'h0;
      out_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking here so every register samples the pre-edge values of the others.
      state_q     <= state_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      out_valid_q <= out_valid_d;
      out_rdata_q <= out_rdata_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign bus_req   = (state_q == REQ);
  assign bus_we    = we_q;
  assign bus_addr  = {addr_q[31:2], 2'b00};
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;
  assign out_valid = out_valid_q;
  assign out_rdata = out_rdata_q;
  assign out_err   = out_err_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit that sits after the execute stage and carries out the memory access that stage describes. It accepts one access at a time: the `defs.vh` `mem_sel` size/sign code, an effective address, store data and a load/store flag. It drives a word-wide request/acknowledge data bus with byte enables, then returns the aligned, sign- or zero-extended load result, or a misalignment error. One access is in flight at most; the pipeline stalls on `in_ready` low.

## Interface
Parameters:
- none (widths fixed at 32-bit data and address; `mem_sel` codes come from `defs.vh`)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  access request from execute side
- `in_ready`  out  1  1 only in IDLE; a request is accepted on a rising edge with `in_valid && in_ready`
- `in_we`  in  1  1 = store, 0 = load
- `in_sel`  in  3  `MEM_B/BU/H/HU/W` or `NOT_MEM`
- `in_addr`  in  32  byte address
- `in_wdata`  in  32  store data, right-justified
- `out_valid`  out  1  one-cycle completion pulse
- `out_rdata`  out  32  extended load data; 0 for stores and errors
- `out_err`  out  1  misaligned access, qualified by `out_valid`
- `bus_req`  out  1  bus request; held until acknowledged
- `bus_we`  out  1  bus write
- `bus_addr`  out  32  word address: `{addr[31:2], 2'b00}`
- `bus_be`  out  4  byte enables; lane k = bits [8k+7:8k], little-endian
- `bus_wdata`  out  32  lane-replicated store data
- `bus_ack`  in  1  slave completion; `bus_rdata` valid in the same cycle
- `bus_rdata`  in  32  read word

## Operation
- FSM with three states:
  - IDLE: `in_ready=1`.
  - REQ: `bus_req=1`.
  - RESP: `out_valid=1`.
- IDLE, accepted request with `in_sel == NOT_MEM`: dropped. No bus activity, no response, state stays IDLE.
- IDLE, accepted request that is misaligned: go to RESP with `out_err=1` and `out_rdata=0`. No bus request is issued.
  - H/HU is misaligned when `addr[0]=1`.
  - W is misaligned when `addr[1:0]≠0`.
  - B/BU is never misaligned.
- IDLE, any other accepted request: register `we`, `sel`, `addr` and `wdata`, then go to REQ.
- Byte enables and write data:
  - B/BU: `be = 4'b0001 << addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
  - H/HU: `be = 4'b0011 << {addr[1],1'b0}`, `wdata = {2{wdata[15:0]}}`.
  - W: `be = 4'b1111`, `wdata` passed unchanged.
  - Loads drive the same `be` pattern; `bus_wdata` is don't-care.
- REQ:
  - `bus_*` outputs are stable until `bus_ack`.
  - On `bus_ack`, a load captures `bus_rdata`, selects the addressed lane and extends it: B/H sign-extend, BU/HU zero-extend, W passes through. The FSM then goes to RESP.
  - A store yields `out_rdata=0`.
- RESP: `out_valid=1` for exactly one cycle, then IDLE. `out_rdata` and `out_err` hold their values until the next completion.
- `bus_ack` is ignored outside REQ.
- `in_valid` is ignored while `in_ready=0`; a request stays pending on the execute side.

## Timing
- Reset values:
  - State is IDLE.
  - `in_ready=1`.
  - `out_valid=0`, `out_rdata=0`, `out_err=0`.
  - `bus_req=0`, `bus_we=0`, `bus_addr=0`, `bus_be=0`, `bus_wdata=0`.
- Reset mid-REQ clears `bus_req` asynchronously. A late `bus_ack` after reset is ignored.
- Let edge E be the accepting edge.
  - `bus_req` rises after E.
  - With `bus_ack` in that first REQ cycle, `out_valid` is high in the cycle after edge E+2.
  - Each extra wait cycle adds one cycle.
- Error path: `out_valid` is high in the cycle after edge E+1.
- Back-to-back accesses: IDLE lasts at least one cycle between accesses, so the best-case throughput is one access per 3 cycles.
- `bus_req` and `bus_ack` high in the same cycle is a completed transfer; `bus_req` drops on the next edge.

## Test plan
- LB at 0x1003 with `bus_rdata=0x80FF_1234`, immediate ack:
  - `bus_be=0001`<<3 = 1000, `bus_addr=0x1000`.
  - `out_rdata=0xFFFF_FF80`, `out_valid` 3 cycles after `in_valid`.
  - LBU at the same address returns `0x0000_0080`.
- SH of `0x0000_BEEF` at 0x2002, ack after 3 wait cycles:
  - `bus_req` is held for 4 cycles with `be=1100` and `wdata=0xBEEF_BEEF`.
  - `out_valid` pulses once with `out_rdata=0`.
- LW at 0x3001: `out_err=1` with `out_valid` 2 cycles after `in_valid`; `bus_req` never rises.
- LH at 0x3001 also flags an error; LB at 0x3001 does not.
- `in_valid` with `NOT_MEM`: no `bus_req`, no `out_valid`, `in_ready` stays 1.
- `in_valid` held high during REQ: the second access is accepted only on the edge after RESP.
- Spurious `bus_ack` while IDLE changes nothing.
- `rst` pulsed mid-REQ:
  - `bus_req` drops immediately and `in_ready=1`.
  - A following `bus_ack` produces no `out_valid`.
  - The next LW at 0x4000 completes normally.
